// File: rtl/sel8_rr_arb.sv
// sel8_rr_arb: round-robin arbiter sequencing a 3-to-8 enabled selector (req_i[7:0] in; s2_o..s0_o, en_o, tout_o, busy_o out)
module sel8_rr_arb #(
  parameter int MAXHOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  output logic       s2_o,
  output logic       s1_o,
  output logic       s0_o,
  output logic       en_o,
  output logic       tout_o,
  output logic       busy_o
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t     state_q, state_d;
  logic [2:0] s_q, s_d, last_q, last_d, base, idx, win;
  logic [7:0] cnt_q, cnt_d;
  logic       tout_q, tout_d;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= 3'd0;
      last_q  <= 3'd7;
      cnt_q   <= 8'd0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  // In GAP the pointer is taken from the code just served, so that owner
  // drops to lowest priority in the same cycle it is released.
  always_comb begin
    base    = state_q == GAP ? s_q : last_q;
    idx     = base;
    win     = base;
    for (int k = 8; k >= 1; k--) begin
      idx = base + 3'(k);
      if (req_i[idx]) win = idx;
    end
    state_d = state_q;
    s_d     = s_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    if (state_q == GRANT) begin
      cnt_d = cnt_q + 8'd1;
      if (!req_i[s_q]) state_d = GAP;
      else if (cnt_q == 8'(MAXHOLD - 1)) begin
        state_d = GAP;
        tout_d  = 1'b1;
      end
    end else begin
      if (state_q == GAP) last_d = s_q;
      state_d = |req_i ? GRANT : IDLE;
      s_d     = |req_i ? win : s_q;
      cnt_d   = |req_i ? 8'd0 : cnt_q;
    end
  end
  always_comb begin
    {s2_o, s1_o, s0_o} = s_q;
    en_o   = state_q == GRANT;
    busy_o = state_q == GRANT;
    tout_o = tout_q;
  end
endmodule
